cache_port_arbiter: RTL and testbench

Two-port round-robin front end that shares a single cache_controller between requester 0 (fetch side) and requester 1 (load/store side). It latches one requester's operation, issues it to the cache, and waits for cache ready. It then returns data_out/hit to the granted requester with a one-cycle ack. It also keeps access and hit counters for hit-rate reporting.

---
 rtl/cache_port_arbiter.sv | 139 +++++++++++++
 tb/tb_cache_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_port_arbiter.sv
// Two-port round-robin front end sharing one cache_controller between a fetch port (0)
// and a load/store port (1), with saturating access/hit statistics.
module cache_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_req,
    input  logic              r0_opcode,
    input  logic [DATA_W-1:0] r0_data_in,
    input  logic [ADDR_W-1:0] r0_address,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_data_out,
    output logic              r0_hit,

    input  logic              r1_req,
    input  logic              r1_opcode,
    input  logic [DATA_W-1:0] r1_data_in,
    input  logic [ADDR_W-1:0] r1_address,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_data_out,
    output logic              r1_hit,

    output logic              c_valid,
    output logic              c_opcode,
    output logic [DATA_W-1:0] c_data_in,
    output logic [ADDR_W-1:0] c_address,
    input  logic [DATA_W-1:0] c_data_out,
    input  logic              c_hit,
    input  logic              c_ready,

    input  logic              stats_clr,
    output logic [CNT_W-1:0]  access_cnt,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e              state_q, state_d;
    logic                grant_q, last_grant_q, grant_sel;
    logic                c_opcode_q;
    logic [DATA_W-1:0]   c_data_in_q;
    logic [ADDR_W-1:0]   c_address_q;
    logic [DATA_W-1:0]   r0_data_q, r1_data_q;
    logic                r0_hit_q, r1_hit_q;
    logic [CNT_W-1:0]    access_q, hit_q;
    logic                resp_hit;

    // On contention the port that was not served last wins; otherwise whoever asks.
    assign grant_sel = (r0_req && r1_req) ? ~last_grant_q : r1_req;
    assign resp_hit  = grant_q ? r1_hit_q : r0_hit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (r0_req || r1_req) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (c_ready) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        c_valid = (state_q == StIssue);
        busy    = (state_q != StIdle);
        r0_ack  = (state_q == StResp) && !grant_q;
        r1_ack  = (state_q == StResp) && grant_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            c_opcode_q   <= 1'b0;
            c_data_in_q  <= '0;
            c_address_q  <= '0;
            r0_data_q    <= '0;
            r0_hit_q     <= 1'b0;
            r1_data_q    <= '0;
            r1_hit_q     <= 1'b0;
        end else begin
            if (state_q == StIdle && (r0_req || r1_req)) begin
                grant_q     <= grant_sel;
                c_opcode_q  <= grant_sel ? r1_opcode  : r0_opcode;
                c_data_in_q <= grant_sel ? r1_data_in : r0_data_in;
                c_address_q <= grant_sel ? r1_address : r0_address;
            end
            if (state_q == StWait && c_ready) begin
                if (grant_q) begin
                    r1_data_q <= c_data_out;
                    r1_hit_q  <= c_hit;
                end else begin
                    r0_data_q <= c_data_out;
                    r0_hit_q  <= c_hit;
                end
            end
            if (state_q == StResp) begin
                last_grant_q <= grant_q;
            end
        end
    end

    // Clear takes priority over a coincident RESP increment.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            access_q <= '0;
            hit_q    <= '0;
        end else if (state_q == StResp) begin
            if (access_q != CntMax) access_q <= access_q + 1'b1;
            if (resp_hit && hit_q != CntMax) hit_q <= hit_q + 1'b1;
        end
    end

    assign c_opcode    = c_opcode_q;
    assign c_data_in   = c_data_in_q;
    assign c_address   = c_address_q;
    assign r0_data_out = r0_data_q;
    assign r0_hit      = r0_hit_q;
    assign r1_data_out = r1_data_q;
    assign r1_hit      = r1_hit_q;
    assign access_cnt  = access_q;
    assign hit_cnt     = hit_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: per-cycle vector table plus hand-written
// sequences for arbitration order, long cache latency, mid-op reset and saturation.
module tb_cache_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;  // small counters so saturation is reachable quickly

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_req, r0_opcode, r0_ack, r0_hit;
    logic [DW-1:0] r0_data_in, r0_data_out;
    logic [AW-1:0] r0_address;
    logic          r1_req, r1_opcode, r1_ack, r1_hit;
    logic [DW-1:0] r1_data_in, r1_data_out;
    logic [AW-1:0] r1_address;
    logic          c_valid, c_opcode, c_hit, c_ready;
    logic [DW-1:0] c_data_in, c_data_out;
    logic [AW-1:0] c_address;
    logic          stats_clr, busy;
    logic [CW-1:0] access_cnt, hit_cnt;

    int checks = 0;
    int failures = 0;

    cache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_opcode(r0_opcode), .r0_data_in(r0_data_in),
        .r0_address(r0_address), .r0_ack(r0_ack), .r0_data_out(r0_data_out), .r0_hit(r0_hit),
        .r1_req(r1_req), .r1_opcode(r1_opcode), .r1_data_in(r1_data_in),
        .r1_address(r1_address), .r1_ack(r1_ack), .r1_data_out(r1_data_out), .r1_hit(r1_hit),
        .c_valid(c_valid), .c_opcode(c_opcode), .c_data_in(c_data_in), .c_address(c_address),
        .c_data_out(c_data_out), .c_hit(c_hit), .c_ready(c_ready),
        .stats_clr(stats_clr), .access_cnt(access_cnt), .hit_cnt(hit_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst; logic q0; logic op0; logic [7:0] d0; logic [31:0] a0;
        logic q1; logic op1; logic [7:0] d1; logic [31:0] a1;
        logic rdy; logic [7:0] cd; logic ch; logic clr;
        logic e_valid; logic e_op; logic [7:0] e_din; logic [31:0] e_addr;
        logic e_ack0; logic [7:0] e_d0; logic e_h0;
        logic e_ack1; logic [7:0] e_d1; logic e_h1;
        logic e_busy; logic [3:0] e_acc; logic [3:0] e_hit;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        r0_req = 0; r0_opcode = 0; r0_data_in = '0; r0_address = '0;
        r1_req = 0; r1_opcode = 0; r1_data_in = '0; r1_address = '0;
        c_ready = 0; c_data_out = '0; c_hit = 0; stats_clr = 0;
    endtask

    task automatic wait_valid(output logic ok);
        int n = 0;
        while (!c_valid && n < 50) begin
            tick();
            n++;
        end
        ok = c_valid;
    endtask

    // Acts as the cache for one transaction; port=-1 if no issue or no single ack seen.
    task automatic serve(input int dly, input logic [7:0] d, input logic h, output int port,
                         output logic [31:0] addr, output logic op, output logic [7:0] din);
        logic ok;
        port = -1; addr = '0; op = 0; din = '0;
        wait_valid(ok);
        if (ok) begin
            addr = c_address; op = c_opcode; din = c_data_in;
            tick();
            repeat (dly) tick();
            c_ready = 1; c_data_out = d; c_hit = h;
            tick();
            c_ready = 0;
            if (r0_ack && !r1_ack) port = 0;
            else if (r1_ack && !r0_ack) port = 1;
            tick();
        end
    endtask

    vec_t vt[20];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int port;
        logic [31:0] addr;
        logic op, ok;
        logic [7:0] din;
        int bad, acks;

        // rst q0 op0 d0 a0 | q1 op1 d1 a1 | rdy cd ch clr ||
        //   valid op din addr | ack0 d0 h0 | ack1 d1 h1 | busy acc hit
        vt[0]  = '{1,0,0,0,0,        0,0,0,0,         0,0,0,0,   0,0,0,0,        0,0,0,    0,0,0,    0,0,0};
        vt[1]  = '{1,0,0,0,0,        0,0,0,0,         0,0,0,0,   0,0,0,0,        0,0,0,    0,0,0,    0,0,0};
        vt[2]  = '{0,0,0,0,0,        0,0,0,0,         1,'h77,1,0, 0,0,0,0,       0,0,0,    0,0,0,    0,0,0};
        vt[3]  = '{0,1,0,0,'h10,     0,0,0,0,         0,0,0,0,   1,0,0,'h10,     0,0,0,    0,0,0,    1,0,0};
        vt[4]  = '{0,1,0,0,'h10,     0,0,0,0,         1,'hEE,1,0, 0,0,0,'h10,    0,0,0,    0,0,0,    1,0,0};
        vt[5]  = '{0,1,0,0,'h10,     0,0,0,0,         1,'h00,0,0, 0,0,0,'h10,    1,0,0,    0,0,0,    1,0,0};
        vt[6]  = '{0,0,0,0,0,        0,0,0,0,         1,'h33,1,0, 0,0,0,0,       0,0,0,    0,0,0,    0,1,0};
        vt[7]  = '{0,1,0,0,'h10,     0,0,0,0,         0,0,0,0,   1,0,0,'h10,     0,0,0,    0,0,0,    1,1,0};
        vt[8]  = '{0,1,0,0,'h10,     0,0,0,0,         0,0,0,0,   0,0,0,'h10,     0,0,0,    0,0,0,    1,1,0};
        vt[9]  = '{0,1,0,0,'h10,     0,0,0,0,         0,0,0,0,   0,0,0,'h10,     0,0,0,    0,0,0,    1,1,0};
        vt[10] = '{0,1,0,0,'h10,     0,0,0,0,         1,'h5A,1,0, 0,0,0,'h10,    1,'h5A,1, 0,0,0,    1,1,0};
        vt[11] = '{0,0,0,0,0,        0,0,0,0,         0,0,0,0,   0,0,0,0,        0,'h5A,1, 0,0,0,    0,2,1};
        vt[12] = '{0,0,0,0,0,        1,1,'hC3,'h200,  0,0,0,0,   1,1,'hC3,'h200, 0,'h5A,1, 0,0,0,    1,2,1};
        vt[13] = '{0,0,0,0,0,        1,1,'hC3,'h200,  0,0,0,0,   0,1,'hC3,'h200, 0,'h5A,1, 0,0,0,    1,2,1};
        vt[14] = '{0,0,0,0,0,        1,1,'hC3,'h200,  1,'h11,1,0, 0,1,'hC3,'h200, 0,'h5A,1, 1,'h11,1, 1,2,1};
        vt[15] = '{0,0,0,0,0,        0,0,0,0,         0,0,0,0,   0,0,0,0,        0,'h5A,1, 0,'h11,1, 0,3,2};
        vt[16] = '{0,1,0,0,'h20,     0,0,0,0,         0,0,0,0,   1,0,0,'h20,     0,'h5A,1, 0,'h11,1, 1,3,2};
        vt[17] = '{0,1,0,0,'h20,     0,0,0,0,         0,0,0,0,   0,0,0,'h20,     0,'h5A,1, 0,'h11,1, 1,3,2};
        vt[18] = '{0,1,0,0,'h20,     0,0,0,0,         1,'h99,1,0, 0,0,0,'h20,    1,'h99,1, 0,'h11,1, 1,3,2};
        vt[19] = '{0,0,0,0,0,        0,0,0,0,         0,0,0,1,   0,0,0,0,        0,'h99,1, 0,'h11,1, 0,0,0};

        clear_inputs();
        rst = 1;
        tick();

        for (int i = 0; i < 20; i++) begin
            rst = vt[i].rst;
            r0_req = vt[i].q0; r0_opcode = vt[i].op0; r0_data_in = vt[i].d0;
            r0_address = vt[i].a0;
            r1_req = vt[i].q1; r1_opcode = vt[i].op1; r1_data_in = vt[i].d1;
            r1_address = vt[i].a1;
            c_ready = vt[i].rdy; c_data_out = vt[i].cd; c_hit = vt[i].ch;
            stats_clr = vt[i].clr;
            tick();
            check($sformatf("v%0d c_valid", i), 32'(c_valid), 32'(vt[i].e_valid));
            check($sformatf("v%0d busy", i), 32'(busy), 32'(vt[i].e_busy));
            check($sformatf("v%0d r0_ack", i), 32'(r0_ack), 32'(vt[i].e_ack0));
            check($sformatf("v%0d r1_ack", i), 32'(r1_ack), 32'(vt[i].e_ack1));
            check($sformatf("v%0d r0_data_out", i), 32'(r0_data_out), 32'(vt[i].e_d0));
            check($sformatf("v%0d r0_hit", i), 32'(r0_hit), 32'(vt[i].e_h0));
            check($sformatf("v%0d r1_data_out", i), 32'(r1_data_out), 32'(vt[i].e_d1));
            check($sformatf("v%0d r1_hit", i), 32'(r1_hit), 32'(vt[i].e_h1));
            check($sformatf("v%0d access_cnt", i), 32'(access_cnt), 32'(vt[i].e_acc));
            check($sformatf("v%0d hit_cnt", i), 32'(hit_cnt), 32'(vt[i].e_hit));
            if (vt[i].e_busy || vt[i].rst) begin
                check($sformatf("v%0d c_address", i), c_address, vt[i].e_addr);
                check($sformatf("v%0d c_opcode", i), 32'(c_opcode), 32'(vt[i].e_op));
                check($sformatf("v%0d c_data_in", i), 32'(c_data_in), 32'(vt[i].e_din));
            end
        end

        // Round-robin with both ports requesting continuously from reset.
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        r0_req = 1; r0_opcode = 1; r0_data_in = 8'hA5; r0_address = 32'h80;
        r1_req = 1; r1_opcode = 0; r1_data_in = 8'h00; r1_address = 32'h100;
        for (int i = 0; i < 4; i++) begin
            serve(0, 8'(8'h40 + i), 1'(i % 2), port, addr, op, din);
            check($sformatf("rr%0d grant", i), 32'(port), 32'(i % 2));
            check($sformatf("rr%0d c_address", i), addr, (i % 2 == 1) ? 32'h100 : 32'h80);
            check($sformatf("rr%0d c_opcode", i), 32'(op), (i % 2 == 1) ? 32'd0 : 32'd1);
            check($sformatf("rr%0d c_data_in", i), 32'(din), (i % 2 == 1) ? 32'h00 : 32'hA5);
        end
        r0_req = 0; r1_req = 0;
        tick();
        check("rr access_cnt", 32'(access_cnt), 32'd4);
        check("rr hit_cnt", 32'(hit_cnt), 32'd2);
        check("rr r0_data_out", 32'(r0_data_out), 32'h42);
        check("rr r1_data_out", 32'(r1_data_out), 32'h43);

        // Long latency on port 1; payload changes after grant must not leak through.
        r1_req = 1; r1_opcode = 0; r1_address = 32'h300;
        wait_valid(ok);
        check("long issued", 32'(ok), 32'd1);
        r1_address = 32'h999; r1_opcode = 1;
        bad = 0;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (c_address !== 32'h300 || c_opcode !== 1'b0 || c_valid !== 1'b0) bad++;
            if (r1_ack || r0_ack) acks++;
        end
        check("long busy while waiting", 32'(busy), 32'd1);
        c_ready = 1; c_data_out = 8'hD7; c_hit = 1;
        tick();
        c_ready = 0;
        if (r1_ack) acks++;
        if (r0_ack) bad++;
        r1_req = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (r1_ack || r0_ack) acks++;
        end
        check("long c_address stable", 32'(bad), 32'd0);
        check("long r1_ack count", 32'(acks), 32'd1);
        check("long r1_data_out", 32'(r1_data_out), 32'hD7);
        check("long r0_data_out untouched", 32'(r0_data_out), 32'h42);
        check("long r0_hit untouched", 32'(r0_hit), 32'd0);
        check("long access_cnt", 32'(access_cnt), 32'd5);
        check("long hit_cnt", 32'(hit_cnt), 32'd3);

        // Reset while waiting on the cache drops the transaction.
        r0_req = 1; r0_opcode = 0; r0_address = 32'h40;
        wait_valid(ok);
        tick();
        tick();
        rst = 1; r0_req = 0;
        tick();
        rst = 0;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst acks", 32'({r0_ack, r1_ack}), 32'd0);
        check("midrst access_cnt", 32'(access_cnt), 32'd0);
        check("midrst hit_cnt", 32'(hit_cnt), 32'd0);
        check("midrst r0_data_out", 32'(r0_data_out), 32'd0);
        tick();
        check("midrst no ack after", 32'({r0_ack, r1_ack, c_valid}), 32'd0);
        r0_req = 1; r0_address = 32'h44;
        serve(2, 8'h3C, 1, port, addr, op, din);
        check("fresh grant", 32'(port), 32'd0);
        check("fresh c_address", addr, 32'h44);
        check("fresh r0_data_out", 32'(r0_data_out), 32'h3C);
        check("fresh access_cnt", 32'(access_cnt), 32'd1);

        // 15 more hits take both 4-bit counters past their maximum.
        for (int i = 0; i < 15; i++) begin
            serve(0, 8'(i), 1, port, addr, op, din);
            if (i == 13) begin
                check("sat reach access_cnt", 32'(access_cnt), 32'd15);
            end
        end
        r0_req = 0;
        tick();
        check("sat access_cnt", 32'(access_cnt), 32'd15);
        check("sat hit_cnt", 32'(hit_cnt), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
